// File: rtl/sonar_frame_tx.sv
// Sonar frame transmitter: sends "aaa,ddd#" as 7E2 UART characters and pulses pronto at the end.
// Optional macro SONAR_FRAME_CRLF_EN appends CR/LF to every frame.
module sonar_frame_tx #(
    parameter int unsigned BIT_TICKS = 434,
    parameter int unsigned TICK_W    = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inicio,
    input  logic [11:0] dados,
    input  logic [23:0] angulos,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

`ifdef SONAR_FRAME_CRLF_EN
    localparam int unsigned NCHAR = 10;
`else
    localparam int unsigned NCHAR = 8;
`endif
    localparam int unsigned CIDX_W = $clog2(NCHAR);
    localparam int unsigned CHAR_W = 7;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD     = 4'd1,
        START    = 4'd2,
        DATA     = 4'd3,
        PARIDADE = 4'd4,
        STOP     = 4'd5,
        PROXIMO  = 4'd6,
        FIM      = 4'd7
    } state_t;

    state_t state, state_d;

    logic [3*CHAR_W-1:0]             ang_q;
    logic [11:0]                     dat_q;
    logic [NCHAR-1:0][CHAR_W-1:0]    frame_q, frame_d;
    logic [CIDX_W-1:0]               char_idx;
    logic [2:0]                      bit_idx;
    logic [TICK_W-1:0]               tick_cnt;
    logic [CHAR_W-1:0]               cur_char;
    logic                            tick_end, timed, last_char;
    logic                            bit_clr, bit_inc, char_inc;
    logic                            line_d, busy_d;

    // Bit 7 of each angle character never reaches the line.
    logic unused_ang_msb;
    assign unused_ang_msb = ^{angulos[23], angulos[15], angulos[7]};

    function automatic logic [CHAR_W-1:0] bcd_ascii(input logic [3:0] n);
        return (n > 4'd9) ? 7'h3F : 7'(7'h30 + {3'b000, n});
    endfunction

    assign tick_end  = (tick_cnt == TICK_W'(BIT_TICKS - 1));
    assign timed     = (state == START) || (state == DATA) || (state == PARIDADE) || (state == STOP);
    assign last_char = (char_idx == CIDX_W'(NCHAR - 1));
    assign cur_char  = frame_q[char_idx];
    assign db_estado = state;

    // Character buffer contents built from the captured measurement.
    always_comb begin
        frame_d    = '0;
        frame_d[0] = ang_q[20:14];
        frame_d[1] = ang_q[13:7];
        frame_d[2] = ang_q[6:0];
        frame_d[3] = 7'h2C;
        frame_d[4] = bcd_ascii(dat_q[11:8]);
        frame_d[5] = bcd_ascii(dat_q[7:4]);
        frame_d[6] = bcd_ascii(dat_q[3:0]);
        frame_d[7] = 7'h23;
`ifdef SONAR_FRAME_CRLF_EN
        frame_d[8] = 7'h0D;
        frame_d[9] = 7'h0A;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, line level and counter control; PROXIMO is resolved inside the last STOP tick.
    always_comb begin
        state_d  = state;
        line_d   = 1'b1;
        bit_clr  = 1'b0;
        bit_inc  = 1'b0;
        char_inc = 1'b0;
        busy_d   = 1'b0;
        case (state)
            IDLE: begin
                if (inicio) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d = START;
                busy_d  = 1'b1;
            end
            START: begin
                line_d = 1'b0;
                busy_d = 1'b1;
                if (tick_end) begin
                    state_d = DATA;
                    bit_clr = 1'b1;
                end
            end
            DATA: begin
                line_d = cur_char[bit_idx];
                busy_d = 1'b1;
                if (tick_end) begin
                    if (bit_idx == 3'd6) begin
                        state_d = PARIDADE;
                        bit_clr = 1'b1;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARIDADE: begin
                line_d = ^cur_char;
                busy_d = 1'b1;
                if (tick_end) begin
                    state_d = STOP;
                    bit_clr = 1'b1;
                end
            end
            STOP: begin
                busy_d = 1'b1;
                if (tick_end) begin
                    if (bit_idx == 3'd1) begin
                        bit_clr = 1'b1;
                        if (last_char) begin
                            state_d = FIM;
                        end else begin
                            state_d  = START;
                            char_inc = 1'b1;
                        end
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PROXIMO: begin
                busy_d  = 1'b1;
                bit_clr = 1'b1;
                if (last_char) begin
                    state_d = FIM;
                end else begin
                    state_d  = START;
                    char_inc = 1'b1;
                end
            end
            FIM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Input capture, character buffer and bit/char/tick counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ang_q    <= '0;
            dat_q    <= '0;
            frame_q  <= '0;
            char_idx <= '0;
            bit_idx  <= '0;
            tick_cnt <= '0;
        end else begin
            if ((state == IDLE) && inicio) begin
                ang_q <= {angulos[22:16], angulos[14:8], angulos[6:0]};
                dat_q <= dados;
            end
            if (state == LOAD) begin
                frame_q  <= frame_d;
                char_idx <= '0;
                bit_idx  <= '0;
                tick_cnt <= '0;
            end else begin
                if (timed) begin
                    tick_cnt <= tick_end ? '0 : tick_cnt + TICK_W'(1);
                end
                if (bit_clr) begin
                    bit_idx <= '0;
                end else if (bit_inc) begin
                    bit_idx <= bit_idx + 3'd1;
                end
                if (char_inc) begin
                    char_idx <= char_idx + CIDX_W'(1);
                end
            end
        end
    end

    // Registered outputs trail the state by one cycle, keeping the line glitch-free.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saida_serial <= 1'b1;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            saida_serial <= line_d;
            ocupado      <= busy_d;
            pronto       <= (state == FIM);
        end
    end

endmodule

// File: tb/tb_sonar_frame_tx.sv
// Directed bench for sonar_frame_tx: decodes the UART line and compares against hand-written frames.
module tb_sonar_frame_tx;

    localparam int unsigned BT = 4;
    localparam int unsigned TW = 3;
`ifdef SONAR_FRAME_CRLF_EN
    localparam int NCH = 10;
    localparam string SUFFIX = "\r\n";
`else
    localparam int NCH = 8;
    localparam string SUFFIX = "";
`endif

    logic        clock;
    logic        reset;
    logic        inicio;
    logic [11:0] dados;
    logic [23:0] angulos;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    int checks;
    int failures;
    int pronto_cnt;
    logic par_seen [0:15];

    sonar_frame_tx #(
        .BIT_TICKS (BT),
        .TICK_W    (TW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .inicio       (inicio),
        .dados        (dados),
        .angulos      (angulos),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pronto === 1'b1) pronto_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the falling edge of a start bit; returns cycles waited.
    task automatic wait_start(output int cnt);
        cnt = 0;
        while (cnt < 20) begin
            @(posedge clock);
            cnt++;
            #1;
            if (saida_serial === 1'b0) break;
        end
    endtask

    task automatic run_frame(input logic [23:0] ang, input logic [11:0] dad,
                             input string exp, input bit busy_poke);
        int cnt;
        int bad;
        int p0;
        logic [6:0] rx;
        logic [3:0] fr;
        logic smp;
        byte e;
        p0  = pronto_cnt;
        bad = 0;
        @(negedge clock);
        angulos = ang;
        dados   = dad;
        inicio  = 1'b1;
        @(posedge clock);
        #1;
        inicio  = 1'b0;
        angulos = 24'h000000;
        dados   = 12'hFFF;
        check("load_state", 32'({ocupado, db_estado}), 32'h11);
        wait_start(cnt);
        check("start_latency", 32'(cnt), 32'd2);
        for (int c = 0; c < NCH; c++) begin
            rx = '0;
            fr = '0;
            for (int b = 0; b < 11; b++) begin
                repeat (BT / 2) @(posedge clock);
                #1;
                smp = saida_serial;
                if (ocupado !== 1'b1 || pronto !== 1'b0) bad++;
                if (b == 0) fr[3] = smp;
                else if (b <= 7) rx[b-1] = smp;
                else if (b == 8) fr[2] = smp;
                else if (b == 9) fr[1] = smp;
                else fr[0] = smp;
                if (busy_poke && c == 1 && b == 5) begin
                    inicio = 1'b1;
                    dados  = 12'h999;
                end
                if (busy_poke && c == 2 && b == 0) inicio = 1'b0;
                repeat (BT - BT / 2) @(posedge clock);
            end
            e = exp[c];
            par_seen[c] = fr[2];
            check($sformatf("char%0d", c), 32'(rx), 32'(e[6:0]));
            check($sformatf("framing%0d", c), 32'(fr), 32'({1'b0, ^e[6:0], 2'b11}));
        end
        check("busy_during_frame", 32'(bad), 32'd0);
        #1;
        check("pronto_edge", 32'({pronto, ocupado, saida_serial}), 32'(3'b101));
        @(posedge clock);
        #1;
        check("pronto_one_cycle", 32'({pronto, db_estado}), 32'h00);
        check("pronto_count", 32'(pronto_cnt - p0), 32'd1);
    endtask

    initial begin
        int cnt;
        int bad;
        int p0;
        checks     = 0;
        failures   = 0;
        pronto_cnt = 0;
        reset      = 1'b0;
        inicio     = 1'b0;
        dados      = 12'h000;
        angulos    = 24'h000000;

        // Reset held with inicio toggling
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            inicio = ~inicio;
            check("reset_hold", 32'({saida_serial, ocupado, pronto, db_estado}), 32'h40);
        end
        @(negedge clock);
        reset  = 1'b1;
        inicio = 1'b0;
        repeat (3) @(negedge clock);

        run_frame(24'h303230, 12'h125, {"020,125#", SUFFIX}, 1'b0);
        check("parity_char0", 32'(par_seen[0]), 32'd0);
        check("parity_comma", 32'(par_seen[3]), 32'd1);

        run_frame(24'h313830, 12'h1A9, {"180,1?9#", SUFFIX}, 1'b0);
        run_frame(24'hB1B2B3, 12'h000, {"123,000#", SUFFIX}, 1'b0);

        // Busy re-trigger with changed data must not queue a second frame
        run_frame(24'h303930, 12'h345, {"090,345#", SUFFIX}, 1'b1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (saida_serial !== 1'b1 || db_estado !== 4'd0 || pronto !== 1'b0) bad++;
        end
        check("no_requeue", 32'(bad), 32'd0);

        // Reset during the third character's data bits
        p0 = pronto_cnt;
        @(negedge clock);
        angulos = 24'h313233;
        dados   = 12'h456;
        inicio  = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        wait_start(cnt);
        check("mid_start_latency", 32'(cnt), 32'd2);
        repeat (2 * 11 * BT + 3 * BT + 2) @(posedge clock);
        #1;
        check("mid_line_before_reset", 32'({saida_serial, db_estado}), 32'h03);
        reset = 1'b0;
        #1;
        check("mid_reset_outputs", 32'({saida_serial, ocupado, pronto, db_estado}), 32'h40);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check("mid_reset_no_pronto", 32'(pronto_cnt - p0), 32'd0);
        run_frame(24'h313233, 12'h456, {"123,456#", SUFFIX}, 1'b0);

        run_frame(24'h303030, 12'h007, {"000,007#", SUFFIX}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
